// File: rtl/rr_port_arbiter.sv
// Five-port round-robin output arbiter with packet locking and downstream credit tracking.
// A port holds the output from grant until its tail flit is forwarded.
module rr_port_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic [4:0] tail,
  input  logic       credit_in,
  output logic [4:0] gnt,
  output logic       fwd,
  output logic [2:0] credits,
  output logic       busy
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  ptr, ptr_nxt;
  logic [2:0]  owner, owner_nxt;
  logic [4:0]  gnt_nxt;
  logic [2:0]  credits_nxt;
  logic [2:0]  win;
  logic        win_vld;
  int unsigned idx;

  // First requester found scanning ptr, ptr+1, ... modulo 5.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < 5; k++) begin
      idx = (32'(ptr) + k) % 5;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win     = idx[2:0];
      end
    end
  end

  assign fwd  = (state == LOCK) && req[owner] && (credits != '0);
  assign busy = (state == LOCK);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (win_vld) begin
          state_nxt = LOCK;
          owner_nxt = win;
          gnt_nxt   = 5'b00001 << win;
        end
      end
      LOCK: begin
        if (fwd && tail[owner]) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = (owner == 3'd4) ? 3'd0 : owner + 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // Simultaneous forward and returned credit cancel out; returns beyond DEPTH are dropped.
  always_comb begin
    credits_nxt = credits;
    if (fwd && !credit_in)
      credits_nxt = credits - 3'd1;
    else if (!fwd && credit_in && (credits != DEPTH_C))
      credits_nxt = credits + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      ptr     <= '0;
      owner   <= '0;
      credits <= DEPTH_C;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      ptr     <= ptr_nxt;
      owner   <= owner_nxt;
      credits <= credits_nxt;
    end
  end

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Directed bench for rr_port_arbiter: rotation, stalls, credits, reset and wrap-around.
module tb_rr_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req;
  logic [4:0] tail;
  logic       credit_in;
  logic [4:0] gnt;
  logic       fwd;
  logic [2:0] credits;
  logic       busy;

  int checks = 0;
  int errors = 0;

  rr_port_arbiter #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .tail      (tail),
    .credit_in (credit_in),
    .gnt       (gnt),
    .fwd       (fwd),
    .credits   (credits),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; tail = '0; credit_in = 1'b0;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 5'b11111; tail = 5'b00000; credit_in = 1'b1;
    step();
    checks++;
    if (gnt !== 5'b00000 || busy !== 1'b0 || credits !== 3'd4 || fwd !== 1'b0) begin
      errors++;
      $display("FAIL reset: gnt=%b busy=%b credits=%0d fwd=%b, want gnt=00000 busy=0 credits=4 fwd=0",
               gnt, busy, credits, fwd);
    end
    rst = 1'b0; req = '0; credit_in = 1'b0;
    #1;
  endtask

  task automatic test_rotation();
    logic [4:0] exp_gnt [7] = '{5'b00010, 5'b00000, 5'b00100, 5'b00000,
                                5'b10000, 5'b00000, 5'b00010};
    do_reset();
    req = 5'b10110; tail = 5'b11111;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (gnt !== exp_gnt[i] || busy !== (exp_gnt[i] != 5'b0)) begin
        errors++;
        $display("FAIL rotation[%0d]: gnt=%b busy=%b, want gnt=%b busy=%b",
                 i, gnt, busy, exp_gnt[i], exp_gnt[i] != 5'b0);
      end
      if (exp_gnt[i] != 5'b0 && i < 6) begin
        checks++;
        if (fwd !== 1'b1) begin
          errors++;
          $display("FAIL rotation_fwd[%0d]: fwd=%b, want 1", i, fwd);
        end
      end
    end
    checks++;
    if (credits !== 3'd1) begin
      errors++;
      $display("FAIL rotation_credits: credits=%0d, want 1", credits);
    end
  endtask

  task automatic test_stall();
    do_reset();
    req = 5'b00100; tail = 5'b00000;
    step();
    checks++;
    if (gnt !== 5'b00100 || fwd !== 1'b1) begin
      errors++;
      $display("FAIL stall_grant: gnt=%b fwd=%b, want gnt=00100 fwd=1", gnt, fwd);
    end
    step();
    req = 5'b00001;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (fwd !== 1'b0 || gnt !== 5'b00100) begin
        errors++;
        $display("FAIL stall_gap[%0d]: gnt=%b fwd=%b, want gnt=00100 fwd=0", i, gnt, fwd);
      end
      step();
    end
    req = 5'b00100;
    #1;
    checks++;
    if (fwd !== 1'b1 || gnt !== 5'b00100 || credits !== 3'd3) begin
      errors++;
      $display("FAIL stall_resume: gnt=%b fwd=%b credits=%0d, want gnt=00100 fwd=1 credits=3",
               gnt, fwd, credits);
    end
    step();
    tail = 5'b00100;
    #1;
    step();
    checks++;
    if (gnt !== 5'b00000 || busy !== 1'b0 || credits !== 3'd1) begin
      errors++;
      $display("FAIL stall_release: gnt=%b busy=%b credits=%0d, want gnt=00000 busy=0 credits=1",
               gnt, busy, credits);
    end
    req = 5'b00101; tail = 5'b00000;
    step();
    checks++;
    if (gnt !== 5'b00001) begin
      errors++;
      $display("FAIL stall_next: gnt=%b, want 00001", gnt);
    end
  endtask

  task automatic test_credits();
    do_reset();
    req = 5'b00001; tail = 5'b00000;
    step();
    for (int c = 4; c >= 1; c--) begin
      checks++;
      if (credits !== 3'(c) || fwd !== 1'b1) begin
        errors++;
        $display("FAIL credits_drain[%0d]: credits=%0d fwd=%b, want credits=%0d fwd=1",
                 c, credits, fwd, c);
      end
      step();
    end
    step();
    checks++;
    if (credits !== 3'd0 || fwd !== 1'b0 || gnt !== 5'b00001) begin
      errors++;
      $display("FAIL credits_empty: credits=%0d fwd=%b gnt=%b, want credits=0 fwd=0 gnt=00001",
               credits, fwd, gnt);
    end
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    #1;
    checks++;
    if (credits !== 3'd1 || fwd !== 1'b1) begin
      errors++;
      $display("FAIL credits_return: credits=%0d fwd=%b, want credits=1 fwd=1", credits, fwd);
    end
    step();
    checks++;
    if (credits !== 3'd0 || fwd !== 1'b0) begin
      errors++;
      $display("FAIL credits_consume: credits=%0d fwd=%b, want credits=0 fwd=0", credits, fwd);
    end
  endtask

  task automatic test_credit_simul();
    do_reset();
    req = 5'b00001; tail = 5'b00000;
    step();
    step();
    step();
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    checks++;
    if (credits !== 3'd2) begin
      errors++;
      $display("FAIL credit_both: credits=%0d, want 2", credits);
    end
    do_reset();
    credit_in = 1'b1;
    step();
    step();
    credit_in = 1'b0;
    checks++;
    if (credits !== 3'd4 || gnt !== 5'b00000) begin
      errors++;
      $display("FAIL credit_saturate: credits=%0d gnt=%b, want credits=4 gnt=00000", credits, gnt);
    end
  endtask

  task automatic test_reset_midpacket();
    do_reset();
    req = 5'b01000; tail = 5'b00000;
    step();
    step();
    rst = 1'b1; req = 5'b11111;
    step();
    checks++;
    if (gnt !== 5'b00000 || busy !== 1'b0 || credits !== 3'd4 || fwd !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: gnt=%b busy=%b credits=%0d fwd=%b, want gnt=00000 busy=0 credits=4 fwd=0",
               gnt, busy, credits, fwd);
    end
    rst = 1'b0;
    step();
    checks++;
    if (gnt !== 5'b00001) begin
      errors++;
      $display("FAIL reset_mid_next: gnt=%b, want 00001", gnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 5'b10000; tail = 5'b11111;
    step();
    step();
    req = 5'b10001;
    step();
    checks++;
    if (gnt !== 5'b00001) begin
      errors++;
      $display("FAIL wrap_first: gnt=%b, want 00001", gnt);
    end
    step();
    step();
    checks++;
    if (gnt !== 5'b10000) begin
      errors++;
      $display("FAIL wrap_second: gnt=%b, want 10000", gnt);
    end
    do_reset();
    req = 5'b01000; tail = 5'b11111;
    step();
    step();
    req = 5'b01001;
    step();
    checks++;
    if (gnt !== 5'b00001) begin
      errors++;
      $display("FAIL wrap_ptr4: gnt=%b, want 00001", gnt);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_stall();
    test_credits();
    test_credit_simul();
    test_reset_midpacket();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_port_arbiter.md
RR_PORT_ARBITER -- requirements
Module: rr_port_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, downstream input-buffer depth in flits (credit count ceiling), legal range 1..7.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  5  per-input-port request; bit i=1 means port i presents a valid flit for this output port.
REQ-005 tail  input  5  per-port tail marker; bit i qualifies the flit on port i as last of packet, meaningful only with req[i].
REQ-006 credit_in  input  1  one-cycle pulse: downstream freed one buffer slot.
REQ-007 gnt  output  5  registered one-hot grant (all-zero when no owner).
REQ-008 fwd  output  1  combinational; 1 = flit of owning port transferred this cycle.
REQ-009 credits  output  3  current downstream credit count.
REQ-010 busy  output  1  registered; 1 while a packet holds the output (state LOCK).

Function
REQ-011 FSM SHALL have exactly two states: IDLE (no owner) and LOCK (owner port held for a whole packet).
REQ-012 Round-robin pointer ptr (0..4) SHALL define priority: in IDLE, winner = first i with req[i]=1 scanning ptr, ptr+1, ... mod 5.
REQ-013 IDLE with req!=0 at edge n SHALL move to LOCK at edge n, gnt one-hot on winner and busy=1 from cycle n+1.
REQ-014 IDLE with req=0 SHALL remain IDLE, gnt=0, ptr unchanged.
REQ-015 fwd SHALL equal (state==LOCK) AND req[owner] AND (credits!=0); no dependence on other ports' req/tail.
REQ-016 LOCK SHALL be held while no tail transfer occurs, including when req[owner] deasserts mid-packet (stall, no release, no re-arbitration).
REQ-017 fwd=1 with tail[owner]=1 SHALL move to IDLE at that edge: gnt=0, busy=0 next cycle, ptr=(owner+1) mod 5.
REQ-018 Single-flit packet (req and tail together on first granted cycle) SHALL release after exactly one fwd.
REQ-019 Back-to-back packets SHALL incur exactly one IDLE cycle (gnt=0) between tail transfer and next grant.
REQ-020 Credit update per edge: fwd only -> credits-1; credit_in only -> credits+1; both -> unchanged; neither -> unchanged.
REQ-021 credit_in with credits==DEPTH and no fwd SHALL be ignored (saturate at DEPTH).
REQ-022 credits==0 SHALL force fwd=0; owner keeps gnt until credits return.
REQ-023 gnt SHALL never have more than one bit set; gnt!=0 iff busy=1.
REQ-024 Wrap-around: ptr=4 search order SHALL be 4,0,1,2,3; owner 4 release SHALL set ptr=0.

Reset
REQ-025 rst=1 at an edge SHALL force state=IDLE, gnt=5'b00000, busy=0, ptr=0, credits=DEPTH, overriding all other inputs.
REQ-026 rst asserted mid-packet SHALL drop lock immediately (gnt=0 next cycle) with no tail required; credits restored to DEPTH.
REQ-027 fwd SHALL be 0 in every cycle following a reset edge until a new grant.

Verification
REQ-028 After reset, req=5'b10110 held, all tails=1 -> gnt sequence 00010, 0, 00100, 0, 10000, 0, 00010 (ptr rotation, one bubble between packets).
REQ-029 Port 2 granted, 3-flit packet, req[2] low for 2 cycles mid-packet while req[0]=1 -> gnt stays 00100, fwd=0 during gap, release only on tail.
REQ-030 DEPTH=4, owner streaming, credit_in=0 -> credits 4,3,2,1,0, fwd=0 at 0; single credit_in pulse -> one fwd, credits back to 0.
REQ-031 credits=2 with fwd=1 and credit_in=1 same cycle -> credits stays 2; credit_in at credits=4 with no fwd -> stays 4.
REQ-032 rst pulse during LOCK on port 3 -> next cycle gnt=0, busy=0, credits=DEPTH; with req=5'b11111 next grant is port 0.
REQ-033 Last owner port 4, req=5'b10001 -> next grant port 0 (wrap-around), then port 4.
